// File: rtl/grid_stream_loader_if.sv
// Byte-stream input and flattened-grid output bundle of grid_stream_loader.
// GRID_LOADER_ROLL_COUNT_EN adds the roll_count signal.
interface grid_stream_loader_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
);
  logic [7:0]                    in_data;
  logic                          in_valid;
  logic                          in_last;
  logic                          in_ready;
  logic [WIDTH*DEPTH-1:0]        grid_flat;
  logic                          grid_valid;
  logic                          grid_ready;
  logic [$clog2(DEPTH+1)-1:0]    rows;
  logic [$clog2(WIDTH+1)-1:0]    cols;
  logic                          err;
`ifdef GRID_LOADER_ROLL_COUNT_EN
  logic [$clog2(WIDTH*DEPTH+1)-1:0] roll_count;

  modport master (
    input  in_data, in_valid, in_last, grid_ready,
    output in_ready, grid_flat, grid_valid, rows, cols, err, roll_count
  );
  modport slave (
    output in_data, in_valid, in_last, grid_ready,
    input  in_ready, grid_flat, grid_valid, rows, cols, err, roll_count
  );
`else
  modport master (
    input  in_data, in_valid, in_last, grid_ready,
    output in_ready, grid_flat, grid_valid, rows, cols, err
  );
  modport slave (
    output in_data, in_valid, in_last, grid_ready,
    input  in_ready, grid_flat, grid_valid, rows, cols, err
  );
`endif
endinterface

// File: rtl/grid_stream_loader.sv
// Assembles an ASCII '@'/'.'/LF stream into a DEPTH x WIDTH bit grid with error flagging.
// Optional GRID_LOADER_ROLL_COUNT_EN counts the '@' cells written.
module grid_stream_loader #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic clk,
  input  logic rst,
  grid_stream_loader_if.master bus
);

  localparam int CELLS = WIDTH * DEPTH;
  localparam int COL_W = $clog2(WIDTH + 1);
  localparam int ROW_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(WIDTH);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(DEPTH);

  localparam logic [7:0] CH_ROLL  = 8'h40;
  localparam logic [7:0] CH_EMPTY = 8'h2E;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;

  typedef enum logic [1:0] {LOAD, DRAIN, HOLD} state_t;

  typedef struct packed {
    logic             err;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic [COL_W-1:0] cols;
  } ptr_t;

  state_t           state, state_n;
  logic [CELLS-1:0] grid, grid_n;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col, cols_q;
  logic             err_q;
  ptr_t             p_n;
  logic             take;
`ifdef GRID_LOADER_ROLL_COUNT_EN
  logic [$clog2(CELLS+1)-1:0] rolls, rolls_n;
`endif

  function automatic logic [IDX_W-1:0] cell_idx(input logic [ROW_W-1:0] r,
                                                input logic [COL_W-1:0] c);
    return IDX_W'(int'(r) * WIDTH + int'(c));
  endfunction

  // Close an open row: the first row fixes the row length, later rows must match it.
  function automatic ptr_t end_row(input ptr_t p);
    ptr_t r;
    r = p;
    if (p.col != '0) begin
      if (p.row == '0) begin
        r.cols = p.col;
        r.row  = p.row + 1'b1;
        r.col  = '0;
      end else if (p.col != p.cols) begin
        r.err = 1'b1;
      end else begin
        r.row = p.row + 1'b1;
        r.col = '0;
      end
    end
    return r;
  endfunction

  assign take = bus.in_valid && (state != HOLD);

  always_comb begin
    state_n         = state;
    grid_n          = grid;
    p_n             = '{err: err_q, row: row, col: col, cols: cols_q};
`ifdef GRID_LOADER_ROLL_COUNT_EN
    rolls_n         = rolls;
`endif
    bus.in_ready    = 1'b1;
    bus.grid_valid  = 1'b0;
    case (state)
      LOAD: begin
        if (take) begin
          case (bus.in_data)
            CH_ROLL, CH_EMPTY: begin
              if (p_n.col == COL_MAX || p_n.row == ROW_MAX) begin
                p_n.err = 1'b1;
              end else begin
                grid_n[cell_idx(p_n.row, p_n.col)] = (bus.in_data == CH_ROLL);
`ifdef GRID_LOADER_ROLL_COUNT_EN
                if (bus.in_data == CH_ROLL) rolls_n = rolls + 1'b1;
`endif
                p_n.col = p_n.col + 1'b1;
              end
            end
            CH_LF:   p_n = end_row(p_n);
            CH_CR:   ;
            default: p_n.err = 1'b1;
          endcase
          // A frame may end without a trailing LF; the open row still commits.
          if (bus.in_last && !p_n.err) p_n = end_row(p_n);
          if (bus.in_last)      state_n = HOLD;
          else if (p_n.err)     state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (take && bus.in_last) state_n = HOLD;
      end
      HOLD: begin
        bus.in_ready   = 1'b0;
        bus.grid_valid = 1'b1;
        if (bus.grid_ready) begin
          state_n = LOAD;
          grid_n  = '0;
          p_n     = '0;
`ifdef GRID_LOADER_ROLL_COUNT_EN
          rolls_n = '0;
`endif
        end
      end
      default: state_n = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= LOAD;
      grid   <= '0;
      row    <= '0;
      col    <= '0;
      cols_q <= '0;
      err_q  <= 1'b0;
`ifdef GRID_LOADER_ROLL_COUNT_EN
      rolls  <= '0;
`endif
    end else begin
      state  <= state_n;
      grid   <= grid_n;
      row    <= p_n.row;
      col    <= p_n.col;
      cols_q <= p_n.cols;
      err_q  <= p_n.err;
`ifdef GRID_LOADER_ROLL_COUNT_EN
      rolls  <= rolls_n;
`endif
    end
  end

  assign bus.grid_flat = grid;
  assign bus.rows      = row;
  assign bus.cols      = cols_q;
  assign bus.err       = err_q;
`ifdef GRID_LOADER_ROLL_COUNT_EN
  assign bus.roll_count = rolls;
`endif

endmodule
